regfile_sweep_clear: RTL and testbench



---
 rtl/regfile_sweep_clear.sv | 123 ++++++++++++
 tb/tb_regfile_sweep_clear.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sweep_clear.sv
// Parametrised register file: two combinational read ports, one byte-enabled write port, sweep clear engine.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.

module regfile_sweep_clear_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    wrEn,
  input  logic                    clr,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic [DATA_WIDTH-1:0]   wrData,
  output logic [DATA_WIDTH-1:0]   q
);
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wrEn) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (byteEn[b]) q[8*b +: 8] <= wrData[8*b +: 8];
    end
  end
endmodule

module regfile_sweep_clear #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [ADDR_WIDTH-1:0]   readReg1,
  input  logic [ADDR_WIDTH-1:0]   readReg2,
  output logic [DATA_WIDTH-1:0]   readData1,
  output logic [DATA_WIDTH-1:0]   readData2,
  input  logic [ADDR_WIDTH-1:0]   writeReg,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic                    regWrite,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic                    clearAll,
  output logic                    busy,
  output logic                    errWrite
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                              state, stateNext;
  logic [ADDR_WIDTH-1:0]               sweepCnt;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regQ;
  logic                                idleWr, wrAny;

  assign wrAny  = regWrite & (|byteEn);
  assign idleWr = (state == IDLE) & regWrite & ~clearAll;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (clearAll) stateNext = CLEAR;
      CLEAR:   if (sweepCnt == LAST_REG) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // Counter wraps to 0 on the last sweep edge, so IDLE always sees 0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              sweepCnt <= '0;
    else if (state == CLEAR)  sweepCnt <= sweepCnt + 1'b1;
    else                      sweepCnt <= '0;
  end

  // A real write (nonzero byteEn) is dropped when it collides with a clear request or a running sweep.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) errWrite <= 1'b0;
    else         errWrite <= wrAny & ((state == CLEAR) | clearAll);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gReg
    logic wrSel, clrSel;
    assign wrSel  = (ZERO_REG != 0 && g == 0) ? 1'b0 : (idleWr && writeReg == ADDR_WIDTH'(g));
    assign clrSel = (state == CLEAR) && (sweepCnt == ADDR_WIDTH'(g));
    regfile_sweep_clear_reg #(.DATA_WIDTH(DATA_WIDTH)) uReg (
      .clk    (clk),
      .resetN (resetN),
      .wrEn   (wrSel),
      .clr    (clrSel),
      .byteEn (byteEn),
      .wrData (writeData),
      .q      (regQ[g])
    );
  end

  logic [1:0][ADDR_WIDTH-1:0] rdAddr;
  logic [1:0][DATA_WIDTH-1:0] rdData;

  assign rdAddr    = {readReg2, readReg1};
  assign readData1 = rdData[0];
  assign readData2 = rdData[1];

  for (genvar p = 0; p < 2; p++) begin : gRd
    always_comb begin
      rdData[p] = regQ[rdAddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (idleWr && writeReg == rdAddr[p])
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (byteEn[b]) rdData[p][8*b +: 8] = writeData[8*b +: 8];
`endif
      if (ZERO_REG != 0 && rdAddr[p] == '0) rdData[p] = '0;
    end
  end
endmodule

// File: tb/tb_regfile_sweep_clear.sv
// Bench for regfile_sweep_clear: a ZERO_REG=0 and a ZERO_REG=1 instance driven in lockstep against an array model.
module tb_regfile_sweep_clear;
  logic        clk = 1'b0;
  logic        resetN;
  logic [2:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData;
  logic        regWrite, clearAll;
  logic [3:0]  byteEn;
  logic [31:0] rd1A, rd2A, rd1Z, rd2Z;
  logic        busyA, busyZ, errA, errZ;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mem [2][8];
  logic        mBusy, mErr;
  int          mCnt;

  always #20 clk = ~clk;

  regfile_sweep_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(0)) dutA (
    .clk(clk), .resetN(resetN), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1A), .readData2(rd2A), .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .byteEn(byteEn), .clearAll(clearAll), .busy(busyA), .errWrite(errA));

  regfile_sweep_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(1)) dutZ (
    .clk(clk), .resetN(resetN), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1Z), .readData2(rd2Z), .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .byteEn(byteEn), .clearAll(clearAll), .busy(busyZ), .errWrite(errZ));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expRd(input int z, input logic [2:0] a);
    logic [31:0] v;
    if (z == 1 && a == 3'd0) return 32'd0;
    v = mem[z][a];
`ifdef REGFILE_BYPASS_EN
    if (!mBusy && regWrite && !clearAll && writeReg == a) v = merge(v, writeData, byteEn);
`endif
    return v;
  endfunction

  task automatic modelReset();
    for (int z = 0; z < 2; z++) for (int i = 0; i < 8; i++) mem[z][i] = 32'd0;
    mBusy = 1'b0; mErr = 1'b0; mCnt = 0;
  endtask

  task automatic modelEdge();
    logic e;
    e = regWrite && (byteEn != 4'd0) && (mBusy || clearAll);
    if (mBusy) begin
      mem[0][mCnt] = 32'd0; mem[1][mCnt] = 32'd0;
      mCnt++;
      if (mCnt == 8) begin mBusy = 1'b0; mCnt = 0; end
    end else if (clearAll) begin
      mBusy = 1'b1; mCnt = 0;
    end else if (regWrite) begin
      mem[0][writeReg] = merge(mem[0][writeReg], writeData, byteEn);
      if (writeReg != 3'd0) mem[1][writeReg] = merge(mem[1][writeReg], writeData, byteEn);
    end
    mErr = e;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkOut(input string nm);
    #1;
    chk({nm, ".rd1A"}, rd1A, expRd(0, readReg1));
    chk({nm, ".rd2A"}, rd2A, expRd(0, readReg2));
    chk({nm, ".rd1Z"}, rd1Z, expRd(1, readReg1));
    chk({nm, ".rd2Z"}, rd2Z, expRd(1, readReg2));
    chk({nm, ".busyA"}, 32'(busyA), 32'(mBusy));
    chk({nm, ".busyZ"}, 32'(busyZ), 32'(mBusy));
    chk({nm, ".errA"}, 32'(errA), 32'(mErr));
    chk({nm, ".errZ"}, 32'(errZ), 32'(mErr));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    writeReg = a; writeData = d; byteEn = be; regWrite = 1'b1;
    checkOut("wr");
    tick();
    regWrite = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] data;
    logic [3:0]  be;
    logic [2:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];

  int busyCnt;

  initial begin
    vecs[0] = '{3'd3, 32'hDEADBEEF, 4'hF, 3'd3, 32'hDEADBEEF};
    vecs[1] = '{3'd3, 32'h11223344, 4'h5, 3'd3, 32'hDE22BE44};
    vecs[2] = '{3'd3, 32'h00000000, 4'h0, 3'd3, 32'hDE22BE44};
    vecs[3] = '{3'd1, 32'hAABBCCDD, 4'hA, 3'd1, 32'hAA00CC00};
    vecs[4] = '{3'd1, 32'h00000011, 4'h1, 3'd1, 32'hAA00CC11};
    vecs[5] = '{3'd7, 32'h12345678, 4'h8, 3'd7, 32'h12000000};

    resetN = 1'b0; readReg1 = 3'd0; readReg2 = 3'd0; writeReg = 3'd0;
    writeData = 32'd0; regWrite = 1'b0; byteEn = 4'd0; clearAll = 1'b0;
    modelReset();
    #5;
    checkOut("initReset");
    resetN = 1'b1;

    // async reset pulse between edges wipes a written value
    tick();
    wr(3'd2, 32'h00000005, 4'hF);
    readReg1 = 3'd2;
    checkOut("preRst");
    resetN = 1'b0;
    modelReset();
    #1;
    chk("rstRd1", rd1A, 32'd0);
    chk("rstBusy", 32'(busyA), 32'd0);
    checkOut("rstPulse");
    resetN = 1'b1;

    // table-driven byte-enable writes
    for (int i = 0; i < 6; i++) begin
      readReg1 = vecs[i].ra;
      wr(vecs[i].wa, vecs[i].data, vecs[i].be);
      checkOut("vecPost");
      chk($sformatf("vec%0d", i), rd1A, vecs[i].exp);
    end

    // sweep: fill 1..8, then clear
    for (int i = 0; i < 8; i++) wr(3'(i), 32'(i + 1), 4'hF);
    readReg1 = 3'd2; readReg2 = 3'd3;
    clearAll = 1'b1;
    checkOut("sweepReq");
    tick();
    clearAll = 1'b0;
    busyCnt = 0;
    for (int k = 0; k < 12; k++) begin
      checkOut("sweep");
      if (busyA) busyCnt++;
      if (k == 3) begin
        chk("sweepReg2", rd1A, 32'd0);
        chk("sweepReg3", rd2A, 32'd4);
      end
      tick();
    end
    chk("busyCycles", 32'(busyCnt), 32'd8);
    for (int a = 0; a < 8; a++) begin
      readReg1 = 3'(a);
      checkOut("afterSweep");
      chk("afterSweepZero", rd1A, 32'd0);
    end

    // clear/write collision, then a write during the sweep
    readReg1 = 3'd5; readReg2 = 3'd6;
    writeReg = 3'd5; writeData = 32'd9; byteEn = 4'hF; regWrite = 1'b1; clearAll = 1'b1;
    checkOut("collPre");
    tick();
    regWrite = 1'b0; clearAll = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checkOut("collSweep");
      if (k == 0) chk("collErr", 32'(errA), 32'd1);
      if (k == 1) chk("collErrOnce", 32'(errA), 32'd0);
      if (k == 5) chk("busyWrErr", 32'(errA), 32'd1);
      regWrite = (k == 4);
      writeReg = 3'd6; writeData = 32'd55;
      clearAll = (k == 2);
      tick();
      regWrite = 1'b0; clearAll = 1'b0;
    end
    checkOut("collEnd");
    chk("collReg5", rd1A, 32'd0);
    chk("collReg6", rd2A, 32'd0);

    // zero register behaviour
    readReg1 = 3'd0; readReg2 = 3'd7;
    wr(3'd0, 32'hFFFFFFFF, 4'hF);
    checkOut("zr");
    chk("zrRd", rd1Z, 32'd0);
    chk("zrErr", 32'(errZ), 32'd0);
    chk("nzRd0", rd1A, 32'hFFFFFFFF);
    wr(3'd7, 32'd8, 4'hF);
    checkOut("zr7");
    chk("zrRd7", rd2Z, 32'd8);

    // same-cycle bypass path
    readReg2 = 3'd4;
    writeReg = 3'd4; writeData = 32'd77; byteEn = 4'hF; regWrite = 1'b1;
    checkOut("bypassPre");
`ifdef REGFILE_BYPASS_EN
    chk("bypassRd2", rd2A, 32'd77);
`else
    chk("noBypassRd2", rd2A, 32'd0);
`endif
    tick();
    regWrite = 1'b0;
    checkOut("bypassPost");
    chk("postWrRd2", rd2A, 32'd77);

    // reset mid-sweep
    clearAll = 1'b1;
    tick();
    clearAll = 1'b0;
    for (int k = 0; k < 5; k++) begin checkOut("midSweep"); tick(); end
    resetN = 1'b0;
    modelReset();
    #1;
    chk("midRstBusyA", 32'(busyA), 32'd0);
    chk("midRstBusyZ", 32'(busyZ), 32'd0);
    for (int a = 0; a < 8; a++) begin
      readReg1 = 3'(a);
      checkOut("midRst");
      chk("midRstZero", rd1A, 32'd0);
    end
    resetN = 1'b1;
    readReg1 = 3'd1;
    wr(3'd1, 32'h0000ABCD, 4'hF);
    checkOut("postRstWr");
    chk("postRstWrRd", rd1A, 32'h0000ABCD);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      writeReg  = 3'($urandom);
      readReg1  = 3'($urandom);
      readReg2  = 3'($urandom);
      writeData = $urandom;
      byteEn    = 4'($urandom_range(0, 15));
      regWrite  = 1'($urandom_range(0, 1));
      clearAll  = ($urandom_range(0, 24) == 0);
      checkOut("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
